// File: rtl/iecdrv_fastser.sv
// Fast-serial SP/CNT transceiver for IEC drive models.
// TX/RX FIFOs, programmable bit rate, bit order, RX bit-timeout, sticky errors.
module iecdrv_fastser #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int CLK_DIV    = 4,
  parameter int TIMEOUT    = 255,
  parameter int MSB_FIRST  = 1
) (
  input  logic              clk,
  input  logic              res_n,
  input  logic              ce,
  input  logic              dir_out,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_wr,
  output logic              tx_full,
  output logic              tx_busy,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_rd,
  output logic              err_ovr,
  output logic              err_tmo,
  input  logic              err_clr,
  input  logic              sp_in,
  input  logic              cnt_in,
  output logic              sp_out,
  output logic              cnt_out
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int BW = $clog2(DATA_W);
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_LOW,
    TX_HIGH
  } tx_st_t;

  logic [1:0] sp_s, cnt_s;
  logic       cnt_d;

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      sp_s  <= 2'b11;
      cnt_s <= 2'b11;
      cnt_d <= 1'b1;
    end else begin
      sp_s  <= {sp_s[0], sp_in};
      cnt_s <= {cnt_s[0], cnt_in};
      cnt_d <= cnt_s[1];
    end
  end

  logic [DATA_W-1:0] txm [FIFO_DEPTH];
  logic [AW:0]       twp, trp;
  logic              tx_empty, tx_push, tx_pop;
  logic [DATA_W-1:0] tx_head;

  assign tx_empty = (twp == trp);
  assign tx_full  = (twp == {~trp[AW], trp[AW-1:0]});
  assign tx_push  = tx_wr && (!tx_full || tx_pop);
  assign tx_head  = txm[trp[AW-1:0]];

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) txm[i] <= '0;
      twp <= '0;
      trp <= '0;
    end else begin
      if (tx_push) begin
        txm[twp[AW-1:0]] <= tx_data;
        twp <= twp + 1'b1;
      end
      if (tx_pop) trp <= trp + 1'b1;
    end
  end

  tx_st_t            tx_st, tx_st_n;
  logic [DW-1:0]     tx_div, tx_div_n;
  logic [BW-1:0]     tx_bit, tx_bit_n;
  logic [DATA_W-1:0] tx_sh, tx_sh_n;
  logic              tx_cur;

  assign tx_cur = (MSB_FIRST != 0) ? tx_sh[DATA_W-1] : tx_sh[0];

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      tx_st  <= TX_IDLE;
      tx_div <= '0;
      tx_bit <= '0;
      tx_sh  <= '0;
    end else begin
      tx_st  <= tx_st_n;
      tx_div <= tx_div_n;
      tx_bit <= tx_bit_n;
      tx_sh  <= tx_sh_n;
    end
  end

  always_comb begin
    tx_st_n  = tx_st;
    tx_div_n = tx_div;
    tx_bit_n = tx_bit;
    tx_sh_n  = tx_sh;
    tx_pop   = 1'b0;
    if (!dir_out) begin
      tx_st_n  = TX_IDLE;
      tx_div_n = '0;
      tx_bit_n = '0;
    end else if (ce) begin
      unique case (tx_st)
        TX_IDLE: begin
          if (!tx_empty) begin
            tx_pop   = 1'b1;
            tx_sh_n  = tx_head;
            tx_bit_n = '0;
            tx_div_n = '0;
            tx_st_n  = TX_LOW;
          end
        end
        TX_LOW: begin
          if (tx_div == DIV_LAST) begin
            tx_div_n = '0;
            tx_st_n  = TX_HIGH;
          end else begin
            tx_div_n = tx_div + 1'b1;
          end
        end
        TX_HIGH: begin
          if (tx_div != DIV_LAST) begin
            tx_div_n = tx_div + 1'b1;
          end else begin
            tx_div_n = '0;
            if (tx_bit != BIT_LAST) begin
              tx_sh_n  = (MSB_FIRST != 0) ? (tx_sh << 1) : (tx_sh >> 1);
              tx_bit_n = tx_bit + 1'b1;
              tx_st_n  = TX_LOW;
            end else if (!tx_empty) begin
              // chain straight into the next word: no idle gap
              tx_pop   = 1'b1;
              tx_sh_n  = tx_head;
              tx_bit_n = '0;
              tx_st_n  = TX_LOW;
            end else begin
              tx_st_n = TX_IDLE;
            end
          end
        end
        default: tx_st_n = TX_IDLE;
      endcase
    end
  end

  assign tx_busy = !tx_empty || (tx_st != TX_IDLE);
  assign cnt_out = !(dir_out && tx_st == TX_LOW);
  assign sp_out  = (dir_out && tx_st != TX_IDLE) ? tx_cur : 1'b1;

  logic [DATA_W-1:0] rxm [FIFO_DEPTH];
  logic [AW:0]       rwp, rrp;
  logic              rx_empty, rx_full, rx_pop, rx_push, rx_push_ok;
  logic              rx_edge, rx_tmo, ovr_set;
  logic [BW-1:0]     rx_bit;
  logic [TW-1:0]     rx_tmr;
  logic [DATA_W-1:0] rx_sh, rx_sh_n;

  assign rx_empty   = (rwp == rrp);
  assign rx_full    = (rwp == {~rrp[AW], rrp[AW-1:0]});
  assign rx_valid   = !rx_empty;
  assign rx_data    = rx_empty ? '0 : rxm[rrp[AW-1:0]];
  assign rx_pop     = rx_rd && !rx_empty;
  assign rx_edge    = !dir_out && cnt_s[1] && !cnt_d;
  assign rx_sh_n    = (MSB_FIRST != 0) ? {rx_sh[DATA_W-2:0], sp_s[1]}
                                       : {sp_s[1], rx_sh[DATA_W-1:1]};
  assign rx_push    = rx_edge && (rx_bit == BIT_LAST);
  assign rx_push_ok = rx_push && (!rx_full || rx_pop);
  assign ovr_set    = rx_push && !rx_push_ok;
  assign rx_tmo     = !dir_out && !rx_edge && ce &&
                      (rx_bit != '0) && (rx_tmr == TMO_LAST);

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) rxm[i] <= '0;
      rwp    <= '0;
      rrp    <= '0;
      rx_bit <= '0;
      rx_tmr <= '0;
      rx_sh  <= '0;
    end else begin
      if (rx_push_ok) begin
        rxm[rwp[AW-1:0]] <= rx_sh_n;
        rwp <= rwp + 1'b1;
      end
      if (rx_pop) rrp <= rrp + 1'b1;
      if (dir_out || rx_tmo) begin
        rx_bit <= '0;
        rx_tmr <= '0;
      end else if (rx_edge) begin
        rx_sh  <= rx_sh_n;
        rx_bit <= rx_push ? '0 : rx_bit + 1'b1;
        rx_tmr <= '0;
      end else if (ce && rx_bit != '0) begin
        rx_tmr <= rx_tmr + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      err_ovr <= 1'b0;
      err_tmo <= 1'b0;
    end else begin
      if (ovr_set)      err_ovr <= 1'b1;
      else if (err_clr) err_ovr <= 1'b0;
      if (rx_tmo)       err_tmo <= 1'b1;
      else if (err_clr) err_tmo <= 1'b0;
    end
  end

endmodule

// File: tb/tb_iecdrv_fastser.sv
// Self-checking bench for iecdrv_fastser (default parameters).
// Random stimulus checked against a queue-based waveform/word model.
module tb_iecdrv_fastser;

  localparam int W     = 8;
  localparam int DEPTH = 4;
  localparam int DIV   = 4;
  localparam int TMO   = 255;
  localparam int MSB   = 1;

  logic         clk = 0;
  logic         res_n = 0;
  logic         ce = 0;
  logic         dir_out = 0;
  logic [W-1:0] tx_data = '0;
  logic         tx_wr = 0;
  logic         tx_full, tx_busy;
  logic [W-1:0] rx_data;
  logic         rx_valid;
  logic         rx_rd = 0;
  logic         err_ovr, err_tmo;
  logic         err_clr = 0;
  logic         sp_in = 1;
  logic         cnt_in = 1;
  logic         sp_out, cnt_out;

  int errors = 0;
  int checks = 0;
  logic [W-1:0] txq[$];
  logic [W-1:0] rxq[$];

  iecdrv_fastser #(
    .DATA_W(W), .FIFO_DEPTH(DEPTH), .CLK_DIV(DIV),
    .TIMEOUT(TMO), .MSB_FIRST(MSB)
  ) dut (
    .clk(clk), .res_n(res_n), .ce(ce), .dir_out(dir_out),
    .tx_data(tx_data), .tx_wr(tx_wr), .tx_full(tx_full),
    .tx_busy(tx_busy), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_rd(rx_rd), .err_ovr(err_ovr), .err_tmo(err_tmo),
    .err_clr(err_clr), .sp_in(sp_in), .cnt_in(cnt_in),
    .sp_out(sp_out), .cnt_out(cnt_out)
  );

  always #5 clk = ~clk;

  function automatic logic wire_bit(input logic [W-1:0] w, input int i);
    return (MSB != 0) ? w[W-1-i] : w[i];
  endfunction

  task automatic push_word(input logic [W-1:0] w);
    tx_data = w;
    tx_wr = 1;
    @(negedge clk);
    tx_wr = 0;
  endtask

  task automatic run_tx(input string nm, input bit use_extra,
                        input logic [W-1:0] extra);
    logic [1:0] es[$];
    int idx, cyc;
    bit cew, first;
    for (int k = 0; k < txq.size(); k++)
      for (int i = 0; i < W; i++) begin
        repeat (DIV) es.push_back({1'b0, wire_bit(txq[k], i)});
        repeat (DIV) es.push_back({1'b1, wire_bit(txq[k], i)});
      end
    es.push_back(2'b11);
    idx = 0;
    cyc = 0;
    first = 1;
    while (idx < es.size() && cyc < 20000) begin
      if (first) begin
        ce = 1;
        if (use_extra) begin
          tx_data = extra;
          tx_wr = 1;
        end
        first = 0;
      end else begin
        ce = 1'($urandom_range(0, 1));
      end
      @(posedge clk);
      cew = ce;
      @(negedge clk);
      tx_wr = 0;
      cyc++;
      if (cew) begin
        checks++;
        if ({cnt_out, sp_out} !== es[idx]) begin
          errors++;
          if (errors < 20)
            $display("FAIL %s wave[%0d] cnt,sp=%b exp=%b",
                     nm, idx, {cnt_out, sp_out}, es[idx]);
        end
        idx++;
      end
    end
    checks++;
    if (idx < es.size()) begin
      errors++;
      $display("FAIL %s timeout idx=%0d exp=%0d", nm, idx, es.size());
    end
    checks++;
    if (tx_busy !== 1'b0) begin
      errors++;
      $display("FAIL %s busy_end got=%b exp=0", nm, tx_busy);
    end
    ce = 0;
    txq.delete();
  endtask

  task automatic rx_bit(input logic b);
    sp_in = b;
    cnt_in = 0;
    repeat (4) @(negedge clk);
    cnt_in = 1;
    repeat (4) @(negedge clk);
  endtask

  task automatic rx_word(input logic [W-1:0] w);
    for (int i = 0; i < W; i++) rx_bit(wire_bit(w, i));
  endtask

  task automatic pop_check(input string nm);
    logic [W-1:0] e;
    e = rxq.pop_front();
    checks++;
    if (rx_valid !== 1'b1 || rx_data !== e) begin
      errors++;
      $display("FAIL %s valid=%b data=%h exp=1/%h", nm, rx_valid, rx_data, e);
    end
    rx_rd = 1;
    @(negedge clk);
    rx_rd = 0;
  endtask

  task automatic check_empty(input string nm);
    checks++;
    if (rx_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s rx_valid=%b exp=0", nm, rx_valid);
    end
  endtask

  task automatic pulse_clr();
    err_clr = 1;
    @(negedge clk);
    err_clr = 0;
  endtask

  task automatic check_idle(input string nm);
    logic [9:0] got;
    got = {tx_full, tx_busy, rx_valid, err_ovr, err_tmo,
           sp_out, cnt_out, |rx_data, 2'b00};
    checks++;
    if (got !== 10'b0000011000) begin
      errors++;
      $display("FAIL %s flags=%b exp=0000011000", nm, got);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    check_idle("reset_held");
    res_n = 1;
    @(negedge clk);
    check_idle("reset_rel");
  endtask

  task automatic test_tx();
    dir_out = 1;
    ce = 0;
    @(negedge clk);
    push_word(8'hA5);
    txq.push_back(8'hA5);
    checks++;
    if (tx_busy !== 1'b1) begin
      errors++;
      $display("FAIL tx_busy_push got=%b exp=1", tx_busy);
    end
    run_tx("tx_a5", 0, '0);
    for (int k = 0; k < 2; k++) begin
      logic [W-1:0] w;
      w = W'($urandom);
      push_word(w);
      txq.push_back(w);
    end
    run_tx("tx_rand", 0, '0);
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] w;
    dir_out = 1;
    ce = 0;
    for (int i = 0; i < DEPTH; i++) begin
      w = W'($urandom);
      push_word(w);
      txq.push_back(w);
      checks++;
      if (tx_full !== (i == DEPTH - 1)) begin
        errors++;
        $display("FAIL b2b_full[%0d] got=%b exp=%b", i, tx_full, i == DEPTH - 1);
      end
    end
    push_word(W'($urandom));
    checks++;
    if (tx_full !== 1'b1) begin
      errors++;
      $display("FAIL b2b_full_hold got=%b exp=1", tx_full);
    end
    w = W'($urandom);
    txq.push_back(w);
    run_tx("b2b", 1, w);
  endtask

  task automatic test_rx();
    logic [W-1:0] w;
    dir_out = 0;
    ce = 1;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      w = (k == 0) ? 8'h5A : W'($urandom);
      rx_word(w);
      rxq.push_back(w);
    end
    for (int k = 0; k < 3; k++) pop_check("rx_word");
    check_empty("rx_drained");
  endtask

  task automatic test_overflow();
    logic [W-1:0] w;
    pulse_clr();
    for (int k = 0; k <= DEPTH; k++) begin
      w = W'($urandom);
      rx_word(w);
      if (k < DEPTH) rxq.push_back(w);
      if (k == DEPTH - 1) begin
        checks++;
        if (err_ovr !== 1'b0) begin
          errors++;
          $display("FAIL ovr_early got=%b exp=0", err_ovr);
        end
      end
    end
    checks++;
    if (err_ovr !== 1'b1) begin
      errors++;
      $display("FAIL ovr_set got=%b exp=1", err_ovr);
    end
    for (int k = 0; k < DEPTH; k++) pop_check("ovr_word");
    check_empty("ovr_drained");
    pulse_clr();
    checks++;
    if (err_ovr !== 1'b0) begin
      errors++;
      $display("FAIL ovr_clr got=%b exp=0", err_ovr);
    end
  endtask

  task automatic test_timeout();
    logic [W-1:0] w;
    for (int i = 0; i < 3; i++) rx_bit(1'($urandom));
    repeat (200) @(negedge clk);
    checks++;
    if (err_tmo !== 1'b0) begin
      errors++;
      $display("FAIL tmo_early got=%b exp=0", err_tmo);
    end
    repeat (70) @(negedge clk);
    checks++;
    if (err_tmo !== 1'b1) begin
      errors++;
      $display("FAIL tmo_set got=%b exp=1", err_tmo);
    end
    check_empty("tmo_nopush");
    pulse_clr();
    checks++;
    if (err_tmo !== 1'b0) begin
      errors++;
      $display("FAIL tmo_clr got=%b exp=0", err_tmo);
    end
    w = W'($urandom);
    rx_word(w);
    rxq.push_back(w);
    pop_check("tmo_next");
  endtask

  task automatic test_dir_abort();
    logic [W-1:0] w0, w1;
    w0 = W'($urandom) & 8'h7F;
    w1 = W'($urandom);
    dir_out = 1;
    ce = 0;
    @(negedge clk);
    push_word(w0);
    push_word(w1);
    ce = 1;
    repeat (2) @(negedge clk);
    checks++;
    if ({cnt_out, sp_out} !== 2'b00) begin
      errors++;
      $display("FAIL abort_pre cnt,sp=%b exp=00", {cnt_out, sp_out});
    end
    dir_out = 0;
    #1;
    checks++;
    if ({cnt_out, sp_out} !== 2'b11) begin
      errors++;
      $display("FAIL abort_rel cnt,sp=%b exp=11", {cnt_out, sp_out});
    end
    @(negedge clk);
    ce = 0;
    @(negedge clk);
    dir_out = 1;
    txq.push_back(w1);
    run_tx("abort_keep", 0, '0);
    dir_out = 0;
    ce = 1;
    @(negedge clk);
    for (int i = 0; i < 3; i++) rx_bit(1'($urandom));
    dir_out = 1;
    repeat (2) @(negedge clk);
    dir_out = 0;
    w0 = W'($urandom);
    rx_word(w0);
    rxq.push_back(w0);
    pop_check("abort_rx");
    check_empty("abort_rx_one");
  endtask

  task automatic test_reset_mid();
    dir_out = 1;
    ce = 1;
    @(negedge clk);
    push_word(W'($urandom));
    push_word(W'($urandom));
    push_word(W'($urandom));
    repeat (6) @(negedge clk);
    checks++;
    if (tx_busy !== 1'b1) begin
      errors++;
      $display("FAIL rst_pre busy=%b exp=1", tx_busy);
    end
    @(posedge clk);
    #2 res_n = 0;
    #1;
    checks++;
    if ({sp_out, cnt_out, tx_busy} !== 3'b110) begin
      errors++;
      $display("FAIL rst_async sp,cnt,busy=%b exp=110",
               {sp_out, cnt_out, tx_busy});
    end
    @(negedge clk);
    res_n = 1;
    ce = 0;
    dir_out = 0;
    @(negedge clk);
    check_idle("rst_after");
    dir_out = 1;
    ce = 1;
    repeat (20) @(negedge clk);
    checks++;
    if ({cnt_out, tx_busy} !== 2'b10) begin
      errors++;
      $display("FAIL rst_empty cnt,busy=%b exp=10", {cnt_out, tx_busy});
    end
  endtask

  initial begin
    test_reset();
    test_tx();
    test_back_to_back();
    test_rx();
    test_overflow();
    test_timeout();
    test_dir_abort();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
